mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for the 4 x 8-bit addressed byte-memory array.
- Drives the array's addr/data/store inputs and samples its memory output.
- Sequences each write as setup -> store strobe -> hold, so the level-sensitive byte stores never see address or data change while store is high.
- Returns read data and a one-cycle ack to the granted requester.

Parameters:
- STORE_CYCLES, 1, width of the mem_store pulse in clock cycles. Legal range 1..15; a 4-bit internal counter is used.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  requester A access request; held high until a_ack.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  2  A byte address.
- a_wdata  in  8  A write data.
- a_ack  out  1  A completion pulse, one cycle.
- a_rdata  out  8  A read data; valid when a_ack=1.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as A, for requester B.
- mem_addr  out  2  address to the memory array.
- mem_data  out  8  write data to the memory array.
- mem_store  out  1  store strobe to the memory array.
- mem_rdata  in  8  selected-byte output of the memory array.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset rst_n is asynchronous and active-low.
  - All outputs are registered.
- Reset values:
  - State = IDLE.
  - a_ack = b_ack = 0, mem_store = 0, busy = 0.
  - mem_addr = 0, mem_data = 0, a_rdata = b_rdata = 0.
  - last_grant = B, so A wins the first contention.
- States: IDLE, SETUP, STROBE, HOLD, READ, ACK.
- IDLE (arbitration):
  - req is sampled at the clock edge.
  - Only one req high: grant that requester.
  - Both high: grant the requester other than last_grant.
  - On the grant edge (E0): latch we/addr/wdata into internal registers, update last_grant, drive mem_addr/mem_data from the latched values, go to SETUP.
- Write sequence:
  - E0: enter SETUP; mem_store = 0 for 1 cycle.
  - E1: enter STROBE; mem_store = 1 for exactly STORE_CYCLES cycles.
  - E(1+STORE_CYCLES): enter HOLD; mem_store = 0, mem_addr/mem_data unchanged, for 1 cycle.
  - E(2+STORE_CYCLES): enter ACK; ack = 1 for one cycle.
  - E(3+STORE_CYCLES): return to IDLE.
- Read sequence:
  - E0: enter SETUP.
  - E1: enter READ.
  - E2: mem_rdata is registered into the granted requester's rdata; enter ACK, ack = 1.
  - E3: return to IDLE.
  - mem_store is never asserted on a read.
- Output hold rules:
  - mem_addr/mem_data hold their last values in IDLE and during the non-store states.
  - x_rdata changes only on that requester's read completion and holds otherwise, including across writes.
- Handshake rules:
  - Requesters keep req/we/addr/wdata stable until they sample ack = 1, then deassert req on that same edge.
  - The arbiter always spends at least one IDLE cycle between accesses.
  - A req still high in IDLE after an ack is treated as a new request.
- Request field changes mid-access: ignored; fields are latched at grant.
- Starvation: with both requesters continuously requesting, grants strictly alternate A, B, A, B.
- Reset mid-operation: mem_store and ack drop asynchronously, state returns to IDLE, no ack is issued for the aborted access, and last_grant returns to B.
- busy: high from E0 until the return to IDLE.

Test Plan:
- Single write, STORE_CYCLES = 1: A writes 0x5A to addr 2 -> mem_addr = 2 and mem_data = 0x5A from E0; mem_store high exactly 1 cycle (E1-E2); a_ack pulses E3-E4; b_ack stays 0.
- Read-back: A reads addr 2 after the write -> a_ack pulses at E2 with a_rdata = 0x5A; mem_store stays 0; b_rdata unchanged.
- Contention: a_req and b_req both rise in the same cycle after reset, each requesting 3 writes -> grant order A, B, A, B, A, B; every access gets exactly one ack.
- STORE_CYCLES = 3, write 0xC3 to addr 1 -> mem_store high 3 consecutive cycles; addr/data stable from E0 through HOLD; ack at E5.
- Reset asserted during STROBE -> mem_store = 0 immediately, no ack, busy = 0; after release, the first contention grants A.
- Back-to-back single requester: B issues 4 reads (addrs 0..3, preloaded 0x11, 0x22, 0x33, 0x44) -> b_rdata returns those values in order, one IDLE cycle between accesses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake and memory-array bus for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/array side.
interface mem_port_arbiter_if;
    // Requester A
    logic       a_req;
    logic       a_we;
    logic [1:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_ack;
    logic [7:0] a_rdata;
    // Requester B
    logic       b_req;
    logic       b_we;
    logic [1:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_ack;
    logic [7:0] b_rdata;
    // Byte-memory array
    logic [1:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_store;
    logic [7:0] mem_rdata;
    // Status
    logic       busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_ack, a_rdata, b_ack, b_rdata,
        output mem_addr, mem_data, mem_store, busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  mem_addr, mem_data, mem_store, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for a 4 x 8-bit
// level-sensitive byte-memory array. Writes run setup -> store strobe -> hold
// so address and data never move while mem_store is high. All outputs are
// registered.
module mem_port_arbiter #(
    parameter int unsigned STORE_CYCLES = 1   // mem_store pulse width, 1..15
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        READ   = 3'd4,
        ACK    = 3'd5
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    // Strobe counter load value: counts down to zero across the pulse.
    localparam logic [3:0] STROBE_LAST = 4'(STORE_CYCLES - 1);

    state_e     state_q,     state_d;
    req_e       sel_q,       sel_d;
    req_e       last_q,      last_d;
    logic       we_q,        we_d;
    logic [3:0] cnt_q,       cnt_d;
    logic [1:0] mem_addr_q,  mem_addr_d;
    logic [7:0] mem_data_q,  mem_data_d;
    logic       mem_store_q, mem_store_d;
    logic       a_ack_q,     a_ack_d;
    logic       b_ack_q,     b_ack_d;
    logic [7:0] a_rdata_q,   a_rdata_d;
    logic [7:0] b_rdata_q,   b_rdata_d;
    logic       busy_q,      busy_d;
    logic       grant_b;

    // B wins when it is the only requester, or on contention when A went last.
    assign grant_b = bus.b_req && (!bus.a_req || last_q == REQ_A);

    // Next-state and registered-output decode for the access sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_store_d = 1'b0;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        busy_d      = busy_q;

        unique case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    sel_d      = grant_b ? REQ_B : REQ_A;
                    last_d     = grant_b ? REQ_B : REQ_A;
                    we_d       = grant_b ? bus.b_we    : bus.a_we;
                    mem_addr_d = grant_b ? bus.b_addr  : bus.a_addr;
                    mem_data_d = grant_b ? bus.b_wdata : bus.a_wdata;
                    busy_d     = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (we_q) begin
                    mem_store_d = 1'b1;
                    cnt_d       = STROBE_LAST;
                    state_d     = STROBE;
                end else begin
                    state_d     = READ;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d     = HOLD;
                end else begin
                    cnt_d       = cnt_q - 4'd1;
                    mem_store_d = 1'b1;
                end
            end
            HOLD: begin
                a_ack_d = (sel_q == REQ_A);
                b_ack_d = (sel_q == REQ_B);
                state_d = ACK;
            end
            READ: begin
                a_ack_d = (sel_q == REQ_A);
                b_ack_d = (sel_q == REQ_B);
                if (sel_q == REQ_A) a_rdata_d = bus.mem_rdata;
                else                b_rdata_d = bus.mem_rdata;
                state_d = ACK;
            end
            ACK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= REQ_A;
            last_q      <= REQ_B;
            we_q        <= 1'b0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= 2'd0;
            mem_data_q  <= 8'd0;
            mem_store_q <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= 8'd0;
            b_rdata_q   <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values regardless of statement order.
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_store_q <= mem_store_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_store = mem_store_q;
    assign bus.a_ack     = a_ack_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model (grant rule, byte
// memory contents, access timeline) checks a STORE_CYCLES=1 instance under
// directed and random traffic; a STORE_CYCLES=3 instance gets a directed
// stretched-strobe write and read-back.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [1:0] gap;
    } txn_t;

    localparam int SC1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus1 ();
    mem_port_arbiter_if bus3 ();

    mem_port_arbiter #(.STORE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mem_port_arbiter #(.STORE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // Behavioural byte-memory arrays seen by the two instances.
    logic [7:0] arr1 [4];
    logic [7:0] arr3 [4];
    always @(posedge clk) begin
        if (bus1.mem_store) arr1[bus1.mem_addr] <= bus1.mem_data;
        if (bus3.mem_store) arr3[bus3.mem_addr] <= bus3.mem_data;
    end
    assign bus1.mem_rdata = arr1[bus1.mem_addr];
    assign bus3.mem_rdata = arr3[bus3.mem_addr];

    int         n_checks = 0;
    int         n_fail   = 0;
    txn_t       qa [$];
    txn_t       qb [$];
    int         obs_log [$];
    logic [7:0] ref_mem [4];
    int         last_g;      // 0 = A, 1 = B
    bit         chk_b2b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [1:0] a, input logic [7:0] d,
                                input logic [1:0] gap);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.gap = gap;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit side, input logic req, input txn_t t);
        if (side) begin
            bus1.b_req = req; bus1.b_we = t.we; bus1.b_addr = t.addr; bus1.b_wdata = t.wdata;
        end else begin
            bus1.a_req = req; bus1.a_we = t.we; bus1.a_addr = t.addr; bus1.a_wdata = t.wdata;
        end
    endtask

    // Requester: holds each request until its ack, then drops req.
    task automatic drive_side(input bit side);
        txn_t t;
        bit   got;
        forever begin
            if (side) begin
                if (qb.size() == 0) break;
                t = qb.pop_front();
            end else begin
                if (qa.size() == 0) break;
                t = qa.pop_front();
            end
            repeat (t.gap) @(negedge clk);
            set_req(side, 1'b1, t);
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                step();
                got = side ? bus1.b_ack : bus1.a_ack;
            end
            if (side) check("b_ack_arrived", got, 1'b1);
            else      check("a_ack_arrived", got, 1'b1);
            @(negedge clk);
            set_req(side, 1'b0, t);
        end
    endtask

    // Transaction-level model: predicts each grant and checks its timeline.
    task automatic monitor(input int n);
        int         done, idle, budget, g;
        logic       ra, rb;
        txn_t       ta, tb_, t;
        logic [7:0] pa, pb;
        done = 0; idle = 0; budget = 0;
        while (done < n) begin
            @(posedge clk);
            ra = bus1.a_req; rb = bus1.b_req;
            ta  = mk(bus1.a_we, bus1.a_addr, bus1.a_wdata, 2'd0);
            tb_ = mk(bus1.b_we, bus1.b_addr, bus1.b_wdata, 2'd0);
            #1;
            budget++;
            if (budget > 3000) begin
                check("monitor_budget", done, n);
                return;
            end
            if (!bus1.busy) begin
                if (ra || rb) check("grant_taken", bus1.busy, 1'b1);
                idle++;
                continue;
            end
            check("grant_has_req", ra | rb, 1'b1);
            if (ra && rb) g = (last_g == 1) ? 0 : 1;
            else          g = rb ? 1 : 0;
            last_g = g;
            if (chk_b2b && done > 0) check("b2b_idle_gap", idle, 0);
            idle = 0;
            t  = g ? tb_ : ta;
            pa = bus1.a_rdata;
            pb = bus1.b_rdata;
            check("e0_addr", bus1.mem_addr, t.addr);
            check("e0_data", bus1.mem_data, t.wdata);
            check("e0_store", bus1.mem_store, 1'b0);
            if (t.we) begin
                for (int k = 0; k < SC1; k++) begin
                    step();
                    check("strobe_store", bus1.mem_store, 1'b1);
                    check("strobe_addr", bus1.mem_addr, t.addr);
                    check("strobe_data", bus1.mem_data, t.wdata);
                end
                step();
                check("hold_store", bus1.mem_store, 1'b0);
                check("hold_addr", bus1.mem_addr, t.addr);
                check("hold_data", bus1.mem_data, t.wdata);
                check("hold_no_ack", bus1.a_ack | bus1.b_ack, 1'b0);
                step();
                check("wr_a_ack", bus1.a_ack, g == 0);
                check("wr_b_ack", bus1.b_ack, g == 1);
                check("wr_a_rdata_hold", bus1.a_rdata, pa);
                check("wr_b_rdata_hold", bus1.b_rdata, pb);
                obs_log.push_back(bus1.b_ack ? 1 : 0);
                ref_mem[t.addr] = t.wdata;
            end else begin
                step();
                check("read_store", bus1.mem_store, 1'b0);
                check("read_no_ack", bus1.a_ack | bus1.b_ack, 1'b0);
                step();
                check("rd_a_ack", bus1.a_ack, g == 0);
                check("rd_b_ack", bus1.b_ack, g == 1);
                check("rd_store", bus1.mem_store, 1'b0);
                if (g == 1) begin
                    check("b_rdata", bus1.b_rdata, ref_mem[t.addr]);
                    check("a_rdata_hold", bus1.a_rdata, pa);
                end else begin
                    check("a_rdata", bus1.a_rdata, ref_mem[t.addr]);
                    check("b_rdata_hold", bus1.b_rdata, pb);
                end
                obs_log.push_back(bus1.b_ack ? 1 : 0);
            end
            step();
            check("end_no_ack", bus1.a_ack | bus1.b_ack, 1'b0);
            check("end_busy", bus1.busy, 1'b0);
            check("end_store", bus1.mem_store, 1'b0);
            done++;
        end
    endtask

    task automatic run(input int n);
        @(negedge clk);
        fork
            drive_side(1'b0);
            drive_side(1'b1);
            monitor(n);
        join
    endtask

    initial begin
        int         e0, first, last, n_st, ack_at, unstable, back, acks;
        logic [7:0] rd;
        bit         seen;

        bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = 0; bus1.a_wdata = 0;
        bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = 0; bus1.b_wdata = 0;
        bus3.a_req = 0; bus3.a_we = 0; bus3.a_addr = 0; bus3.a_wdata = 0;
        bus3.b_req = 0; bus3.b_we = 0; bus3.b_addr = 0; bus3.b_wdata = 0;
        last_g  = 1;
        chk_b2b = 0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check("rst_a_ack", bus1.a_ack, 1'b0);
        check("rst_b_ack", bus1.b_ack, 1'b0);
        check("rst_store", bus1.mem_store, 1'b0);
        check("rst_busy", bus1.busy, 1'b0);
        check("rst_mem_addr", bus1.mem_addr, 2'd0);
        check("rst_mem_data", bus1.mem_data, 8'd0);
        check("rst_a_rdata", bus1.a_rdata, 8'd0);
        check("rst_b_rdata", bus1.b_rdata, 8'd0);
        check("rst_d3_busy", bus3.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Stretched strobe: STORE_CYCLES = 3, A writes 0xC3 to addr 1.
        bus3.a_req = 1; bus3.a_we = 1; bus3.a_addr = 2'd1; bus3.a_wdata = 8'hC3;
        e0 = -1; first = -1; last = -1; n_st = 0; ack_at = -1; unstable = 0; back = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (e0 < 0 && bus3.busy) e0 = c;
            if (bus3.mem_store) begin
                n_st++;
                if (first < 0) first = c;
                last = c;
            end
            if (e0 >= 0 && ack_at < 0 && (bus3.mem_addr != 2'd1 || bus3.mem_data != 8'hC3))
                unstable++;
            if (bus3.b_ack) back++;
            if (bus3.a_ack && ack_at < 0) begin
                ack_at = c;
                bus3.a_req = 0;
            end
        end
        check("d3_store_cycles", n_st, 3);
        check("d3_store_start", first - e0, 1);
        check("d3_store_contig", last - first, 2);
        check("d3_ack_time", ack_at - e0, 5);
        check("d3_addr_data_stable", unstable, 0);
        check("d3_b_ack_quiet", back, 0);

        @(negedge clk);
        bus3.b_req = 1; bus3.b_we = 0; bus3.b_addr = 2'd1;
        e0 = -1; ack_at = -1; n_st = 0; rd = 8'h00;
        for (int c = 0; c < 12; c++) begin
            step();
            if (e0 < 0 && bus3.busy) e0 = c;
            if (bus3.mem_store) n_st++;
            if (bus3.b_ack && ack_at < 0) begin
                ack_at = c;
                rd = bus3.b_rdata;
                bus3.b_req = 0;
            end
        end
        check("d3_rd_data", rd, 8'hC3);
        check("d3_rd_ack_time", ack_at - e0, 2);
        check("d3_rd_no_store", n_st, 0);

        // Single write then read-back on the STORE_CYCLES = 1 instance.
        qa.push_back(mk(1'b1, 2'd2, 8'h5A, 2'd0));
        run(1);
        qa.push_back(mk(1'b0, 2'd2, 8'h00, 2'd0));
        run(1);
        check("readback_5a", bus1.a_rdata, 8'h5A);

        // Reset during the store strobe.
        @(negedge clk);
        bus1.a_req = 1; bus1.a_we = 1; bus1.a_addr = 2'd3; bus1.a_wdata = 8'h77;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            seen = bus1.mem_store;
        end
        check("rst_reach_strobe", seen, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_store", bus1.mem_store, 1'b0);
        check("midrst_busy", bus1.busy, 1'b0);
        check("midrst_a_ack", bus1.a_ack, 1'b0);
        check("midrst_mem_addr", bus1.mem_addr, 2'd0);
        bus1.a_req = 0;
        last_g = 1;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus1.a_ack || bus1.b_ack || bus1.busy) acks++;
        end
        check("midrst_no_ack", acks, 0);

        // Contention right after reset: 3 writes each, expect A,B,A,B,A,B.
        obs_log.delete();
        qa.push_back(mk(1'b1, 2'd0, 8'hA0, 2'd0));
        qa.push_back(mk(1'b1, 2'd1, 8'hA1, 2'd0));
        qa.push_back(mk(1'b1, 2'd2, 8'hA2, 2'd0));
        qb.push_back(mk(1'b1, 2'd3, 8'hB0, 2'd0));
        qb.push_back(mk(1'b1, 2'd0, 8'hB1, 2'd0));
        qb.push_back(mk(1'b1, 2'd1, 8'hB2, 2'd0));
        run(6);
        check("grant_count", obs_log.size(), 6);
        for (int i = 0; i < obs_log.size(); i++) check("grant_order", obs_log[i], i % 2);

        // Preload 0x11..0x44, then B reads them back-to-back.
        qa.push_back(mk(1'b1, 2'd0, 8'h11, 2'd0));
        qa.push_back(mk(1'b1, 2'd1, 8'h22, 2'd0));
        qa.push_back(mk(1'b1, 2'd2, 8'h33, 2'd0));
        qa.push_back(mk(1'b1, 2'd3, 8'h44, 2'd0));
        run(4);
        chk_b2b = 1;
        for (int i = 0; i < 4; i++) qb.push_back(mk(1'b0, 2'(i), 8'($urandom), 2'd0));
        run(4);
        chk_b2b = 0;
        check("b2b_last_rdata", bus1.b_rdata, 8'h44);

        // Random mixed traffic from both requesters.
        for (int i = 0; i < 30; i++) begin
            qa.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            8'($urandom), 2'($urandom_range(0, 3))));
            qb.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            8'($urandom), 2'($urandom_range(0, 3))));
        end
        run(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
